mem_arbiter: RTL and testbench
==============================

// Module: mem_arbiter
// PURPOSE
// - Two-requester arbiter for the shared CPU memory port: block_ram plus its address and write-data registers.
// - Requester 0 is the processor controller; requester 1 is a debug/program loader.
// - Sequences each access through the address/data registers into the synchronous RAM.
// - Returns a one-cycle ack per access, plus registered read data.
// PARAMETERS
// - ADDR_WIDTH  8   memory address width, matches program counter width
// - DATA_WIDTH  16  memory word width
// PORTS
// - clk             in   1   system clock; one clock domain
// - reset           in   1   synchronous, active-high reset
// - req0 / req1     in   1   access request; held high until matching ack
// - we0 / we1       in   1   1=write, 0=read; stable while req high
// - addr0 / addr1   in   AW  access address; stable while req high
// - wdata0 / wdata1 in   DW  write data; stable while req high
// - ack0 / ack1     out  1   one-cycle completion pulse
// - rdata0 / rdata1 out  DW  read result; valid from ack, held until that requester's next read completes
// - grant           out  2   one-hot owner of current access; 00 when idle
// - busy            out  1   1 in any state other than IDLE
// - addr_reg_en     out  1   load enable, memory address register
// - addr_reg_data   out  AW  address to memory address register
// - data_reg_en     out  1   load enable, memory write-data register
// - data_reg_data   out  DW  data to memory write-data register
// - mem_wen         out  1   block RAM write enable
// - mem_rdata       in   DW  block RAM read data, 1-cycle synchronous latency
// BEHAVIOUR
// - FSM states, one cycle each: IDLE -> LATCH -> ACCESS -> CAPTURE -> DONE -> IDLE.
// - Latency: req seen in IDLE at cycle 0 gives ack in cycle 4.
//   - Throughput is 1 access per 5 cycles.
//   - DONE always returns to IDLE, so a req still high during DONE is never re-granted.
// - IDLE:
//   - Arbitrates when any req is high; on that edge registers grant, we_sel, addr_sel and wdata_sel.
//   - No req high: stays in IDLE with grant=00.
// - Arbitration:
//   - Round-robin; a last_owner flop updates on every grant.
//   - Both req high: grant goes to the requester that is not last_owner.
//   - After reset, last_owner=1, so requester 0 wins the first tie.
// - LATCH: addr_reg_en=1, data_reg_en=1.
//   - addr_reg_data=addr_sel; data_reg_data=wdata_sel.
//   - data_reg_data=wdata_sel even on reads; harmless.
// - ACCESS: mem_wen=we_sel. The RAM samples the address register on this cycle's closing edge.
// - CAPTURE: on a read, loads rdataN of the owner from mem_rdata at the closing edge. Nothing happens on a write.
// - DONE:
//   - ack of the owner = 1 for exactly this cycle; rdataN is already stable.
//   - Closing edge: grant <= 00, busy drops.
// - All register/RAM control outputs are 0 outside their state. At most one ack per cycle; never both.
// - Requester drops req during an access: the access still completes and ack still pulses.
// - Requester changes we/addr/wdata mid-access: ignored, because the values were latched in IDLE.
// - reset (any state, including mid-access): next cycle IDLE, last_owner=1.
//   - All outputs are 0: grant, busy, ack*, rdata*, mem_wen, both reg enables and both reg data buses.
//   - An in-flight write whose mem_wen cycle has not yet occurred is dropped.
// - Address wrap is the RAM's concern; the full ADDR_WIDTH range is passed through unmodified.
// CONFIGURATION
// - MEM_ARB_STATS_EN defined:
//   - Adds outputs grant_cnt0 and grant_cnt1 (16 bits each).
//   - Each counter increments on that requester's grant edge in IDLE and saturates at 16'hFFFF.
//   - Counters clear on reset.
// - MEM_ARB_STATS_EN undefined: the ports and counters are absent; arbitration behaviour is identical.
// TESTING
// - Reset then req0 write addr=8'h10 wdata=16'hBEEF.
//   - mem_wen=1 in cycle 2 only; ack0 in cycle 4; grant=01 during cycles 1-4.
// - req1 read addr=8'h10 after that write -> rdata1=16'hBEEF at ack1 (cycle 4); rdata0 unchanged.
// - req0 and req1 raised together after reset, both held.
//   - Grant order 0,1,0,1; no ack while the other requester is granted.
// - reset asserted in ACCESS of a write to 8'h20 holding 16'h1234 -> mem_wen=0 next cycle; ack and grant stay 0.
// - req0 dropped in LATCH of a read -> access completes; ack0 in cycle 4; FSM returns to IDLE with no re-grant.
// - MEM_ARB_STATS_EN defined: 3 req0 and 2 req1 accesses -> grant_cnt0=3, grant_cnt1=2; both counters 0 after reset.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester round-robin arbiter for the shared CPU memory port.
// Each access is sequenced IDLE -> LATCH -> ACCESS -> CAPTURE -> DONE.
// Requester 0 is the processor controller and requester 1 is the debug/program loader.
// Optional feature: define MEM_ARB_STATS_EN to add the saturating grant counters
// grant_cnt0 and grant_cnt1.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  we0,
    input  logic                  we1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  ack0,
    output logic                  ack1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1,
    output logic [1:0]            grant,
    output logic                  busy,
    output logic                  addr_reg_en,
    output logic [ADDR_WIDTH-1:0] addr_reg_data,
    output logic                  data_reg_en,
    output logic [DATA_WIDTH-1:0] data_reg_data,
    output logic                  mem_wen,
    input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
    ,
    output logic [15:0]           grant_cnt0,
    output logic [15:0]           grant_cnt1
`endif
);

    typedef enum logic [2:0] {IDLE, LATCH, ACCESS, CAPTURE, DONE} state_t;

    state_t                  state_q, state_d;
    logic [1:0]              grant_q, grant_d;
    logic                    last_owner_q, last_owner_d;
    logic                    we_sel_q, we_sel_d;
    logic [ADDR_WIDTH-1:0]   addr_sel_q, addr_sel_d;
    logic [DATA_WIDTH-1:0]   wdata_sel_q, wdata_sel_d;
    logic [DATA_WIDTH-1:0]   rdata0_q, rdata0_d;
    logic [DATA_WIDTH-1:0]   rdata1_q, rdata1_d;
    logic                    arb_fire;
    logic                    win0;

    // Requester 0 wins when alone, or on a tie when requester 1 owned the last access.
    assign arb_fire = (state_q == IDLE) && (req0 || req1);
    assign win0     = req0 && (!req1 || last_owner_q);

    assign grant  = grant_q;
    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign busy   = (state_q != IDLE);

    // Next-state logic, access-select capture and per-state memory control outputs.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        last_owner_d  = last_owner_q;
        we_sel_d      = we_sel_q;
        addr_sel_d    = addr_sel_q;
        wdata_sel_d   = wdata_sel_q;
        rdata0_d      = rdata0_q;
        rdata1_d      = rdata1_q;
        ack0          = 1'b0;
        ack1          = 1'b0;
        addr_reg_en   = 1'b0;
        addr_reg_data = '0;
        data_reg_en   = 1'b0;
        data_reg_data = '0;
        mem_wen       = 1'b0;
        case (state_q)
            IDLE: begin
                if (arb_fire) begin
                    grant_d      = win0 ? 2'b01 : 2'b10;
                    last_owner_d = !win0;
                    we_sel_d     = win0 ? we0 : we1;
                    addr_sel_d   = win0 ? addr0 : addr1;
                    wdata_sel_d  = win0 ? wdata0 : wdata1;
                    state_d      = LATCH;
                end
            end
            LATCH: begin
                // Write data is loaded on reads too; the RAM ignores it without mem_wen.
                addr_reg_en   = 1'b1;
                addr_reg_data = addr_sel_q;
                data_reg_en   = 1'b1;
                data_reg_data = wdata_sel_q;
                state_d       = ACCESS;
            end
            ACCESS: begin
                mem_wen = we_sel_q;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // RAM output is valid this cycle because it sampled the address at the end of ACCESS.
                if (!we_sel_q) begin
                    if (grant_q[0]) rdata0_d = mem_rdata;
                    else            rdata1_d = mem_rdata;
                end
                state_d = DONE;
            end
            DONE: begin
                ack0    = grant_q[0];
                ack1    = grant_q[1];
                grant_d = 2'b00;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight access.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            grant_q      <= 2'b00;
            last_owner_q <= 1'b1;
            we_sel_q     <= 1'b0;
            addr_sel_q   <= '0;
            wdata_sel_q  <= '0;
            rdata0_q     <= '0;
            rdata1_q     <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_owner_q <= last_owner_d;
            we_sel_q     <= we_sel_d;
            addr_sel_q   <= addr_sel_d;
            wdata_sel_q  <= wdata_sel_d;
            rdata0_q     <= rdata0_d;
            rdata1_q     <= rdata1_d;
        end
    end

`ifdef MEM_ARB_STATS_EN
    logic [15:0] cnt0_q, cnt0_d;
    logic [15:0] cnt1_q, cnt1_d;

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;

    // Count grants per requester, saturating at all-ones.
    always_comb begin
        cnt0_d = cnt0_q;
        cnt1_d = cnt1_q;
        if (arb_fire) begin
            if (win0) begin
                if (cnt0_q != 16'hFFFF) cnt0_d = cnt0_q + 16'd1;
            end else begin
                if (cnt1_q != 16'hFFFF) cnt1_d = cnt1_q + 16'd1;
            end
        end
    end

    // Grant counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt0_q <= 16'd0;
            cnt1_q <= 16'd0;
        end else begin
            cnt0_q <= cnt0_d;
            cnt1_q <= cnt1_d;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed bench for mem_arbiter with a behavioural model of the
// address/data registers and a 1-cycle-latency block RAM.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1;
    logic [7:0]  addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        ack0, ack1;
    logic [15:0] rdata0, rdata1;
    logic [1:0]  grant;
    logic        busy;
    logic        addr_reg_en, data_reg_en, mem_wen;
    logic [7:0]  addr_reg_data;
    logic [15:0] data_reg_data;
    logic [15:0] mem_rdata;
`ifdef MEM_ARB_STATS_EN
    logic [15:0] grant_cnt0, grant_cnt1;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    mem_arbiter #(.ADDR_WIDTH(8), .DATA_WIDTH(16)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
        .grant(grant), .busy(busy),
        .addr_reg_en(addr_reg_en), .addr_reg_data(addr_reg_data),
        .data_reg_en(data_reg_en), .data_reg_data(data_reg_data),
        .mem_wen(mem_wen), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
        , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    always #5 clk = ~clk;

    // Memory-side model: address/data registers feeding a synchronous RAM.
    logic [15:0] ram [256];
    logic [7:0]  areg;
    logic [15:0] dreg;
    initial begin
        for (int i = 0; i < 256; i++) ram[i] = 16'h0000;
        areg = 8'h00;
        dreg = 16'h0000;
        mem_rdata = 16'h0000;
    end
    always @(posedge clk) begin
        if (addr_reg_en) areg <= addr_reg_data;
        if (data_reg_en) dreg <= data_reg_data;
        if (mem_wen) ram[areg] <= dreg;
        mem_rdata <= ram[areg];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // One full access by requester r starting in an IDLE cycle; ends in the following IDLE cycle.
    task automatic run_access(input int r);
        if (r == 0) begin req0 = 1'b1; we0 = 1'b0; addr0 = 8'h01; end
        else        begin req1 = 1'b1; we1 = 1'b0; addr1 = 8'h02; end
        tick();
        req0 = 1'b0;
        req1 = 1'b0;
        tick(); tick(); tick(); tick();
    endtask

    initial begin
        reset = 1'b0;
        req0 = 1'b0; req1 = 1'b0; we0 = 1'b0; we1 = 1'b0;
        addr0 = 8'h00; addr1 = 8'h00; wdata0 = 16'h0000; wdata1 = 16'h0000;
        do_reset();

        // Reset state.
        check("rst_grant", grant, 2'b00);
        check("rst_busy", busy, 1'b0);
        check("rst_acks", {ack0, ack1}, 2'b00);
        check("rst_rdata0", rdata0, 16'h0000);
        check("rst_rdata1", rdata1, 16'h0000);
        check("rst_memctl", {mem_wen, addr_reg_en, data_reg_en}, 3'b000);

        // req0 write 8'h10 <= 16'hBEEF; this is cycle 0.
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h10; wdata0 = 16'hBEEF;
        tick(); // cycle 1, LATCH
        check("wr_c1_grant", grant, 2'b01);
        check("wr_c1_busy", busy, 1'b1);
        check("wr_c1_wen", mem_wen, 1'b0);
        check("wr_c1_regen", {addr_reg_en, data_reg_en}, 2'b11);
        check("wr_c1_areg", addr_reg_data, 8'h10);
        check("wr_c1_dreg", data_reg_data, 16'hBEEF);
        addr0 = 8'h55; wdata0 = 16'h0BAD; // mid-access change must be ignored
        tick(); // cycle 2, ACCESS
        check("wr_c2_wen", mem_wen, 1'b1);
        check("wr_c2_regen", {addr_reg_en, data_reg_en}, 2'b00);
        check("wr_c2_grant", grant, 2'b01);
        tick(); // cycle 3, CAPTURE
        check("wr_c3_wen", mem_wen, 1'b0);
        check("wr_c3_ack", {ack0, ack1}, 2'b00);
        tick(); // cycle 4, DONE
        check("wr_c4_ack", {ack0, ack1}, 2'b10);
        check("wr_c4_grant", grant, 2'b01);
        req0 = 1'b0; we0 = 1'b0;
        tick(); // IDLE
        check("wr_c5_grant", grant, 2'b00);
        check("wr_c5_busy", busy, 1'b0);
        check("wr_c5_ack", {ack0, ack1}, 2'b00);
        check("wr_ram", ram[8'h10], 16'hBEEF);

        // req1 read of 8'h10.
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h10;
        tick();
        check("rd_c1_grant", grant, 2'b10);
        tick();
        check("rd_c2_wen", mem_wen, 1'b0);
        tick();
        tick();
        check("rd_c4_ack", {ack0, ack1}, 2'b01);
        check("rd_c4_rdata1", rdata1, 16'hBEEF);
        check("rd_c4_rdata0", rdata0, 16'h0000);
        req1 = 1'b0;
        tick();
        check("rd_c5_ack", {ack0, ack1}, 2'b00);
        check("rd_c5_rdata1_hold", rdata1, 16'hBEEF);

        // Tie after reset: both held, reads from different addresses.
        do_reset();
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        req1 = 1'b1; we1 = 1'b0; addr1 = 8'h20;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("tie_grant", grant, (k % 2 == 0) ? 2'b01 : 2'b10);
            check("tie_latch_ack", {ack0, ack1}, 2'b00);
            tick(); tick(); tick();
            check("tie_done_ack", {ack0, ack1}, (k % 2 == 0) ? 2'b10 : 2'b01);
            tick();
            check("tie_idle_grant", grant, 2'b00);
        end
        check("tie_rdata0", rdata0, 16'hBEEF);
        check("tie_rdata1", rdata1, 16'h0000);
        req0 = 1'b0; req1 = 1'b0;

        // Reset during ACCESS of a write to 8'h20.
        req0 = 1'b1; we0 = 1'b1; addr0 = 8'h20; wdata0 = 16'h1234;
        tick(); // LATCH
        tick(); // ACCESS
        check("rstmid_c2_wen", mem_wen, 1'b1);
        reset = 1'b1;
        req0 = 1'b0; we0 = 1'b0;
        tick();
        check("rstmid_wen", mem_wen, 1'b0);
        check("rstmid_grant", grant, 2'b00);
        check("rstmid_busy", busy, 1'b0);
        check("rstmid_ack", {ack0, ack1}, 2'b00);
        check("rstmid_rdata", {rdata0, rdata1}, 32'h0);
        reset = 1'b0;
        tick();
        check("rstmid_after_ack", {ack0, ack1}, 2'b00);
        check("rstmid_after_grant", grant, 2'b00);

        // req0 read dropped during LATCH.
        req0 = 1'b1; we0 = 1'b0; addr0 = 8'h10;
        tick(); // LATCH
        req0 = 1'b0;
        check("drop_c1_grant", grant, 2'b01);
        tick(); tick(); tick(); // DONE
        check("drop_c4_ack", {ack0, ack1}, 2'b10);
        check("drop_c4_rdata0", rdata0, 16'hBEEF);
        tick();
        check("drop_c5_grant", grant, 2'b00);
        tick();
        check("drop_c6_grant", grant, 2'b00);
        check("drop_c6_busy", busy, 1'b0);

        // Full-range address passes through unmodified.
        req1 = 1'b1; we1 = 1'b1; addr1 = 8'hFF; wdata1 = 16'hA5A5;
        tick();
        check("top_areg", addr_reg_data, 8'hFF);
        req1 = 1'b0;
        tick(); tick(); tick(); tick();
        check("top_ram", ram[8'hFF], 16'hA5A5);

`ifdef MEM_ARB_STATS_EN
        do_reset();
        check("cnt_rst0", grant_cnt0, 16'd0);
        check("cnt_rst1", grant_cnt1, 16'd0);
        for (int i = 0; i < 5; i++) run_access((i < 3) ? 0 : 1);
        check("cnt0", grant_cnt0, 16'd3);
        check("cnt1", grant_cnt1, 16'd2);
        do_reset();
        check("cnt_clr0", grant_cnt0, 16'd0);
        check("cnt_clr1", grant_cnt1, 16'd0);
`else
        run_access(0);
        check("plain_idle_busy", busy, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
